hopfield_update_scheduler: RTL and testbench
============================================

# hopfield_update_scheduler

Sequences asynchronous neuron updates for the Hopfield datapath during the UPDATING phase. On `start` it walks neuron indices 0..NEURON_COUNT-1, one valid/ready handshake per neuron, and records whether any neuron changed state. It repeats full sweeps until a sweep completes with no change (`converged`) or MAX_SWEEPS sweeps run out (`timeout`). It sits between the top-level Hopfield controller, which issues `start` and consumes `converged`, and the neuron-update datapath.

## Interface
- NEURON_COUNT, 16, number of neurons (≥2)
- IDX_W, 4, index width, ≥ clog2(NEURON_COUNT)
- MAX_SWEEPS, 8, sweep limit before timeout (≥1)
- SWEEP_W, 4, sweep counter width, ≥ clog2(MAX_SWEEPS+1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin scheduling; honoured only in IDLE
- abort  in  1  return to IDLE from any state; no `done`
- upd_valid  out  1  request that the datapath update neuron `upd_idx`
- upd_idx  out  IDX_W  neuron index under update
- upd_ready  in  1  datapath accepts/completes the update this cycle
- upd_changed  in  1  neuron flipped state; sampled only on handshake
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse on completion
- converged  out  1  last run ended with a change-free sweep
- timeout  out  1  last run hit MAX_SWEEPS without converging
- sweep_count  out  SWEEP_W  sweeps completed in the current or last run

## Operation
- States: IDLE, ISSUE, CHECK, DONE.
- Reset values: state=IDLE, all outputs 0, upd_idx=0, internal dirty flag=0.
- IDLE: on `start` (and no `abort`), clear converged, timeout, sweep_count, dirty and upd_idx, then go to ISSUE.
- ISSUE: `upd_valid`=1, `upd_idx` stable until handshake (`upd_valid & upd_ready`).
  - On handshake: dirty |= upd_changed.
  - If upd_idx == NEURON_COUNT-1, go to CHECK. Otherwise upd_idx+1.
- CHECK, with sweep_count incremented on entry:
  - If effective dirty==0: converged=1, go to DONE.
  - Else if sweep_count == MAX_SWEEPS: timeout=1, go to DONE.
  - Else: dirty=0, upd_idx=0, go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- converged, timeout and sweep_count hold their values until the next accepted `start`, `abort`, or reset.
- converged and timeout are never both 1.
- `abort` in any state: go to IDLE next cycle. Clear upd_valid, converged and timeout. Keep sweep_count. Issue no `done`. `abort` beats a simultaneous `start` and a simultaneous handshake; upd_changed is not recorded.
- `start` outside IDLE is ignored.
- upd_idx never exceeds NEURON_COUNT-1 and does not wrap inside a sweep.

## Timing
- `start` sampled at edge t: upd_valid=1, upd_idx=0 from t+1.
- With upd_ready held at 1: one neuron per cycle, so one sweep is NEURON_COUNT cycles, plus 1 CHECK cycle.
- Single converging sweep: done=1 and converged=1 in cycle t+NEURON_COUNT+2. busy falls in the same cycle.
- Each upd_ready stall cycle adds one cycle; upd_valid stays high and upd_idx is unchanged while stalled.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset assertion mid-run: outputs go to their reset values immediately (asynchronous). Release is synchronised by the parent.

## Structure
- Shared `hopfield_pkg`: state encoding constants (IDLE/ISSUE/CHECK/DONE) and the default NEURON_COUNT. The top-level Hopfield controller uses the same package.
- Single module, no sub-module. The index and sweep counters are simple enough to stay inline.

## Test plan
Bench parameters: NEURON_COUNT=4, MAX_SWEEPS=3.

- Reset, then idle with rst=1 -> all outputs 0, busy=0; a `start` pulse gives upd_idx sequence 0,1,2,3.
- upd_ready=1, upd_changed=0 always, start at cycle 10 -> done and converged=1 at cycle 16, sweep_count=1, timeout=0.
- upd_changed=1 only on idx 2 of sweep 1 -> second sweep runs; converged=1, sweep_count=2.
- upd_changed=1 always -> three sweeps, then timeout=1, converged=0, sweep_count=3, one done pulse.
- upd_ready low for 3 cycles at idx 1 -> upd_idx held at 1, upd_valid held at 1; done is delayed 3 cycles versus the no-stall run.
- abort with start and handshake in the same cycle at idx 2 -> IDLE next cycle, no done, converged=timeout=0. A `start` pulse while busy is ignored.

Source files
------------

// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield controller and its update scheduler.
package hopfield_pkg;

    // Scheduler state encoding; the top-level controller decodes the same values.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int DEFAULT_NEURON_COUNT = 16;
    localparam int DEFAULT_MAX_SWEEPS   = 8;

endpackage

// File: rtl/hopfield_update_scheduler.sv
// Walks neuron indices through the update datapath, one handshake per neuron,
// repeating sweeps until one sweep changes nothing or the sweep limit is hit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result flags hold last run
// ISSUE | upd_valid high for upd_idx, advance on handshake
// CHECK | sweep finished: converge, time out, or start another sweep
// DONE  | one-cycle done pulse, back to IDLE
module hopfield_update_scheduler
    import hopfield_pkg::*;
#(
    parameter int NEURON_COUNT = DEFAULT_NEURON_COUNT,
    parameter int IDX_W        = 4,
    parameter int MAX_SWEEPS   = DEFAULT_MAX_SWEEPS,
    parameter int SWEEP_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               upd_valid,
    output logic [IDX_W-1:0]   upd_idx,
    input  logic               upd_ready,
    input  logic               upd_changed,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               timeout,
    output logic [SWEEP_W-1:0] sweep_count
);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NEURON_COUNT - 1);
    localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(MAX_SWEEPS);

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic               dirty_q, dirty_d;
    logic               conv_q, conv_d;
    logic               tmo_q, tmo_d;

    // State and result registers; reset forces every output low at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sweep_q <= '0;
            dirty_q <= 1'b0;
            conv_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sweep_q <= sweep_d;
            dirty_q <= dirty_d;
            conv_q  <= conv_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic; abort overrides start and any pending handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sweep_d = sweep_q;
        dirty_d = dirty_q;
        conv_d  = conv_q;
        tmo_d   = tmo_q;
        if (abort) begin
            state_d = ST_IDLE;
            conv_d  = 1'b0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        conv_d  = 1'b0;
                        tmo_d   = 1'b0;
                        sweep_d = '0;
                        dirty_d = 1'b0;
                        idx_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (upd_ready) begin
                        dirty_d = dirty_q | upd_changed;
                        if (idx_q == LAST_IDX) begin
                            // Count the sweep as it completes so CHECK sees the new total.
                            sweep_d = sweep_q + 1'b1;
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (!dirty_q) begin
                        conv_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (sweep_q == LAST_SWEEP) begin
                        tmo_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dirty_d = 1'b0;
                        idx_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign upd_valid   = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_CHECK);
    assign done        = (state_q == ST_DONE);
    assign upd_idx     = idx_q;
    assign converged   = conv_q;
    assign timeout     = tmo_q;
    assign sweep_count = sweep_q;

endmodule

// File: tb/tb_hopfield_update_scheduler.sv
// Bench for hopfield_update_scheduler with four neurons and a three-sweep limit.
module tb_hopfield_update_scheduler;

    localparam int N    = 4;
    localparam int MAXS = 3;
    localparam int BUDGET = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       upd_valid;
    logic [1:0] upd_idx;
    logic       upd_ready = 1'b0;
    logic       upd_changed = 1'b0;
    logic       busy;
    logic       done;
    logic       converged;
    logic       timeout;
    logic [1:0] sweep_count;

    int tests  = 0;
    int failed = 0;

    // Change pattern: chg[sweep][neuron] is what the datapath reports on that handshake.
    bit chg [MAXS][N];

    hopfield_update_scheduler #(
        .NEURON_COUNT(N),
        .IDX_W(2),
        .MAX_SWEEPS(MAXS),
        .SWEEP_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .upd_valid(upd_valid),
        .upd_idx(upd_idx),
        .upd_ready(upd_ready),
        .upd_changed(upd_changed),
        .busy(busy),
        .done(done),
        .converged(converged),
        .timeout(timeout),
        .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_chg();
        for (int s = 0; s < MAXS; s++)
            for (int i = 0; i < N; i++)
                chg[s][i] = 1'b0;
    endtask

    // One full run: the model derives the outcome from the change pattern alone,
    // and the latency from sweeps*(N+1) plus the stall cycles the bench inserted.
    task automatic run_scenario(input string name, input int rdy_pct,
                                input int stall_idx, input int stall_len,
                                output int lat);
        int  exp_s;
        bit  exp_conv;
        bit  found;
        int  hs;
        int  stalls;
        int  cyc;
        int  dones;
        int  stall_left;
        int  sw;
        bit  any;
        exp_s    = MAXS;
        exp_conv = 1'b0;
        found    = 1'b0;
        for (int s = 0; s < MAXS; s++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= chg[s][i];
            if (!any && !found) begin
                found    = 1'b1;
                exp_s    = s + 1;
                exp_conv = 1'b1;
            end
        end

        @(negedge clk);
        start = 1'b1; upd_ready = 1'b1; upd_changed = 1'b0;
        hs = 0; stalls = 0; cyc = 0; dones = 0; stall_left = stall_len;
        while (cyc < BUDGET && dones == 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 3);
            if (cyc == 1) begin
                chk({name, "_clr_conv"}, converged, 0);
                chk({name, "_clr_tmo"}, timeout, 0);
                chk({name, "_clr_sweep"}, sweep_count, 0);
            end
            if (done) begin
                dones++;
            end else begin
                chk({name, "_busy"}, busy, 1);
                if (upd_valid) begin
                    sw = (hs / N < MAXS) ? hs / N : 0;
                    chk({name, "_idx"}, upd_idx, hs % N);
                    chk({name, "_sweep_run"}, sweep_count, hs / N);
                    if (hs == stall_idx && stall_left > 0) begin
                        upd_ready = 1'b0;
                        stall_left--;
                    end else begin
                        upd_ready = ($urandom_range(99) < rdy_pct);
                    end
                    if (upd_ready) begin
                        upd_changed = chg[sw][hs % N];
                        hs++;
                    end else begin
                        upd_changed = 1'($urandom);
                        stalls++;
                    end
                end else begin
                    upd_ready   = 1'($urandom);
                    upd_changed = 1'($urandom);
                end
            end
        end
        start = 1'b0;
        lat = cyc;
        chk({name, "_done_seen"}, dones, 1);
        chk({name, "_done_busy"}, busy, 0);
        chk({name, "_latency"}, cyc, exp_s * (N + 1) + stalls + 1);
        chk({name, "_handshakes"}, hs, exp_s * N);
        chk({name, "_conv"}, converged, exp_conv);
        chk({name, "_tmo"}, timeout, !exp_conv);
        chk({name, "_sweeps"}, sweep_count, exp_s);
        repeat (2) begin
            @(negedge clk);
            chk({name, "_done_once"}, done, 0);
            chk({name, "_hold_conv"}, converged, exp_conv);
            chk({name, "_hold_sweeps"}, sweep_count, exp_s);
        end
    endtask

    int lat_base;
    int lat_stall;
    int lat_tmp;

    initial begin
        // Reset state, both during and after reset.
        #12;
        chk("rst_valid", upd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", upd_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", upd_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_conv", converged, 0);
        chk("idle_tmo", timeout, 0);
        chk("idle_sweep", sweep_count, 0);

        // Single converging sweep.
        clear_chg();
        run_scenario("conv1", 100, -1, 0, lat_base);
        chk("conv1_lat_abs", lat_base, N + 2);

        // One change in the first sweep forces a second sweep.
        clear_chg();
        chg[0][2] = 1'b1;
        run_scenario("conv2", 100, -1, 0, lat_tmp);

        // Changes everywhere: sweep limit reached.
        for (int s = 0; s < MAXS; s++)
            for (int i = 0; i < N; i++)
                chg[s][i] = 1'b1;
        run_scenario("tmo", 100, -1, 0, lat_tmp);

        // Three stall cycles at index 1.
        clear_chg();
        run_scenario("stall", 100, 1, 3, lat_stall);
        chk("stall_delay", lat_stall - lat_base, 3);

        // Abort from IDLE clears the flags but keeps the sweep count.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_conv", converged, 0);
        chk("abort_idle_sweep", sweep_count, 1);

        // Abort together with start and a changing handshake at index 2.
        @(negedge clk);
        start = 1'b1; upd_ready = 1'b1; upd_changed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_idx", upd_idx, 2);
        chk("abort_pre_valid", upd_valid, 1);
        abort = 1'b1; start = 1'b1; upd_ready = 1'b1; upd_changed = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_valid", upd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_conv", converged, 0);
        chk("abort_tmo", timeout, 0);
        chk("abort_sweep", sweep_count, 0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_stay_idle", busy, 0);
        end

        // Randomized change patterns and ready throttling.
        for (int r = 0; r < 15; r++) begin
            for (int s = 0; s < MAXS; s++)
                for (int i = 0; i < N; i++)
                    chg[s][i] = ($urandom_range(99) < 20);
            run_scenario("rand", 40 + $urandom_range(60), -1, 0, lat_tmp);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; upd_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", upd_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_idx", upd_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
